// File: rtl/key_press_classifier_if.sv
// Key classifier bus: debounced key level in, gesture event pulses and held level out.
`default_nettype none

interface key_press_classifier_if;
  logic key_db;
  logic short_pulse;
  logic long_pulse;
  logic double_pulse;
  logic repeat_pulse;
  logic key_held;

  modport master (
    output key_db,
    input  short_pulse, long_pulse, double_pulse, repeat_pulse, key_held
  );

  modport slave (
    input  key_db,
    output short_pulse, long_pulse, double_pulse, repeat_pulse, key_held
  );
endinterface

`default_nettype wire

// File: rtl/key_press_classifier.sv
// Classifies a debounced key into short/long/double/auto-repeat one-cycle pulses.
`default_nettype none

module key_press_classifier #(
  parameter int CNT_W    = 26,
  parameter int LONG_CYC = 25_000_000,
  parameter int DBL_CYC  = 12_500_000,
  parameter int RPT_CYC  = 5_000_000
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  key_press_classifier_if.slave   kp
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRESS1    = 3'd1;
  localparam logic [2:0] WAIT2     = 3'd2;
  localparam logic [2:0] PRESS2    = 3'd3;
  localparam logic [2:0] LONG_HOLD = 3'd4;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             key_d;
  logic             press;
  logic             rel;
  logic             rpt_hit;

  logic short_q,   long_q,   double_q,   repeat_q;
  logic short_nxt, long_nxt, double_nxt, repeat_nxt;
  logic held;

  assign press = key_d & ~kp.key_db;
  assign rel   = ~key_d & kp.key_db;

  // State, counter, edge history and pulse registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      key_d    <= 1'b1;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      key_d    <= kp.key_db;
      short_q  <= short_nxt;
      long_q   <= long_nxt;
      double_q <= double_nxt;
      repeat_q <= repeat_nxt;
      if ((state_nxt != state) || rpt_hit) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rpt_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (press) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (rel)                    state_nxt = WAIT2;
        else if (cnt == LONG_LAST)  state_nxt = LONG_HOLD;
      end
      WAIT2: begin
        // A press landing on the timeout edge still makes a double.
        if (press)                  state_nxt = PRESS2;
        else if (cnt == DBL_LAST)   state_nxt = IDLE;
      end
      PRESS2: begin
        if (rel) state_nxt = IDLE;
      end
      LONG_HOLD: begin
        if (rel)                    state_nxt = IDLE;
        else if (cnt == RPT_LAST)   rpt_hit   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    repeat_nxt = 1'b0;
    held       = 1'b0;
    case (state)
      PRESS1: begin
        held     = 1'b1;
        long_nxt = ~rel && (cnt == LONG_LAST);
      end
      WAIT2: begin
        short_nxt = ~press && (cnt == DBL_LAST);
      end
      PRESS2: begin
        held       = 1'b1;
        double_nxt = rel;
      end
      LONG_HOLD: begin
        held       = 1'b1;
        repeat_nxt = rpt_hit;
      end
      default: ;
    endcase
  end

  assign kp.short_pulse  = short_q;
  assign kp.long_pulse   = long_q;
  assign kp.double_pulse = double_q;
  assign kp.repeat_pulse = repeat_q;
  assign kp.key_held     = held;

endmodule

`default_nettype wire

// File: tb/tb_key_press_classifier.sv
// Scoreboard bench: stimulus pushes expected (event, edge index); negedge monitor pops and compares.
`default_nettype none

module tb_key_press_classifier;

  localparam int K_SHORT  = 1;
  localparam int K_LONG   = 2;
  localparam int K_DOUBLE = 3;
  localparam int K_REPEAT = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  ev_t  q[$];

  key_press_classifier_if kp_bus();

  key_press_classifier #(
    .CNT_W(8), .LONG_CYC(20), .DBL_CYC(10), .RPT_CYC(5)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .kp(kp_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    q.push_back(e);
  endtask

  // Called at a negedge; sets key so that the edge with index e samples v.
  task automatic drive_at(input int e, input logic v);
    while (cyc < e - 1) @(negedge clk);
    kp_bus.key_db = v;
  endtask

  task automatic check_empty(input string name);
    check(name, q.size(), 0);
  endtask

  // Monitor: every pulse observed must match the head of the scoreboard.
  always @(negedge clk) begin
    int kind;
    ev_t e;
    kind = 0;
    case ({kp_bus.repeat_pulse, kp_bus.double_pulse, kp_bus.long_pulse, kp_bus.short_pulse})
      4'b0000: kind = 0;
      4'b0001: kind = K_SHORT;
      4'b0010: kind = K_LONG;
      4'b0100: kind = K_DOUBLE;
      4'b1000: kind = K_REPEAT;
      default: kind = 7;
    endcase
    if (kind != 0) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got kind %0d at cyc %0d, expected none", kind, cyc);
      end else begin
        e = q.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
          fails++;
          $display("FAIL pulse: got kind %0d at cyc %0d, expected kind %0d at cyc %0d",
                   kind, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int p, r, p2, r2;
    kp_bus.key_db = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {kp_bus.short_pulse, kp_bus.long_pulse, kp_bus.double_pulse,
           kp_bus.repeat_pulse, kp_bus.key_held}, 0);
    rst = 1'b0;

    // 1: short press, release, idle -> short 10 edges after release
    p = cyc + 2; r = p + 6;
    drive_at(p, 1'b0);
    drive_at(r, 1'b1);
    expect_ev(K_SHORT, r + 10);
    drive_at(r + 16, 1'b1);
    check_empty("t1_short");

    // 2a: release coinciding with long terminal count -> release wins, short
    p = cyc + 2; r = p + 20;
    drive_at(p, 1'b0);
    drive_at(r, 1'b1);
    expect_ev(K_SHORT, r + 10);
    drive_at(r + 16, 1'b1);
    check_empty("t2_release_at_19");

    // 2b: one edge longer -> long at +20, release from LONG_HOLD silent
    p = cyc + 2; r = p + 21;
    drive_at(p, 1'b0);
    expect_ev(K_LONG, p + 20);
    drive_at(r, 1'b1);
    drive_at(r + 16, 1'b1);
    check_empty("t2_long_exact");

    // 3: long hold with two repeats, key_held asserted throughout
    p = cyc + 2; r = p + 33;
    drive_at(p, 1'b0);
    expect_ev(K_LONG, p + 20);
    expect_ev(K_REPEAT, p + 25);
    expect_ev(K_REPEAT, p + 30);
    while (cyc < r - 1) begin
      @(negedge clk);
      check("t3_key_held", kp_bus.key_held, 1);
    end
    kp_bus.key_db = 1'b1;
    @(negedge clk);
    check("t3_key_released", kp_bus.key_held, 0);
    drive_at(r + 16, 1'b1);
    check_empty("t3_repeat");

    // 4a: press 3, gap 4, press 3 -> double on second release edge
    p = cyc + 2; r = p + 3; p2 = r + 4; r2 = p2 + 3;
    drive_at(p, 1'b0);
    drive_at(r, 1'b1);
    drive_at(p2, 1'b0);
    drive_at(r2, 1'b1);
    expect_ev(K_DOUBLE, r2);
    drive_at(r2 + 16, 1'b1);
    check_empty("t4_double");

    // 4b: second press on the WAIT2 timeout edge -> still double only
    p = cyc + 2; r = p + 3; p2 = r + 10; r2 = p2 + 3;
    drive_at(p, 1'b0);
    drive_at(r, 1'b1);
    drive_at(p2, 1'b0);
    drive_at(r2, 1'b1);
    expect_ev(K_DOUBLE, r2);
    drive_at(r2 + 16, 1'b1);
    check_empty("t4_double_edge");

    // 5: reset during LONG_HOLD, key kept down -> fresh press after deassert
    p = cyc + 2;
    drive_at(p, 1'b0);
    expect_ev(K_LONG, p + 20);
    drive_at(p + 22, 1'b0);
    rst = 1'b1;
    #1;
    check("t5_reset_outputs",
          {kp_bus.short_pulse, kp_bus.long_pulse, kp_bus.double_pulse,
           kp_bus.repeat_pulse, kp_bus.key_held}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    p = cyc + 1;
    expect_ev(K_LONG, p + 20);
    @(negedge clk);
    check("t5_held_after_reset", kp_bus.key_held, 1);
    drive_at(p + 23, 1'b1);
    drive_at(p + 40, 1'b1);
    check_empty("t5_reset_long");

    // 6: illegal state code recovers to IDLE silently
    force dut.state = 3'd6;
    #1;
    check("t6_held_illegal", kp_bus.key_held, 0);
    release dut.state;
    @(negedge clk);
    check("t6_state_idle", dut.state, 0);
    check("t6_held_idle", kp_bus.key_held, 0);
    repeat (5) @(negedge clk);
    check_empty("t6_no_pulse");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
